incr_step_reg: RTL
==================

Name: incr_step_reg

Overview:
- Sequential stage wrapped around the 4-bit ripple incrementer.
- Holds the operand register that drives the incrementer input (q).
- Captures the incrementer's sum and carry outputs back into q under control of a small run FSM.
- Performs a programmed number of increment steps, with wrap or saturate mode, sticky overflow and a done pulse.

Parameters:
WIDTH, 4, operand width; must match the incrementer width.
RESET_VAL, 0, value loaded into q on reset.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
load  input  1  request to load load_val into q; accepted in IDLE only
load_val  input  WIDTH  value written to q on an accepted load
start  input  1  request to begin a run of step_count increments; accepted in IDLE only
step_count  input  WIDTH  number of increments for the run; 0 is legal
hold  input  1  stalls RUN for the current cycle; no step is taken
sat_mode  input  1  1 = saturate at all-ones; 0 = wrap. Sampled at start and held for the run
inc_sum  input  WIDTH  incrementer sum output (q+1 mod 2^WIDTH)
inc_cout  input  1  incrementer carry-out
q  output  WIDTH  operand register; drives the incrementer input
busy  output  1  high in RUN
done  output  1  one-cycle pulse in DONE
ovf  output  1  sticky; set when a step saw inc_cout=1

Behaviour:
- Reset (rst_n low, asynchronous): q=RESET_VAL, busy=0, done=0, ovf=0, state=IDLE, remaining=0, sat_r=0. Reset mid-run aborts the run immediately; no done pulse follows.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, RUN, DONE.
- IDLE:
  - load=1: q<=load_val, ovf<=0, stay IDLE. load has priority over start in the same cycle, so start is dropped.
  - start=1 (load=0): ovf<=0, sat_r<=sat_mode, remaining<=step_count. Go to RUN if step_count!=0; otherwise go to DONE.
- RUN (busy=1):
  - hold=1: no change to q, remaining or ovf.
  - hold=0: one step is taken:
    - If inc_cout=0: q<=inc_sum.
    - If inc_cout=1 and sat_r=0: q<=inc_sum (wraps to 0) and ovf<=1.
    - If inc_cout=1 and sat_r=1: q is unchanged (stays all-ones) and ovf<=1.
    - remaining<=remaining-1. If remaining==1, go to DONE.
  - load and start are ignored in RUN.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE unconditionally. load and start are ignored in DONE.
- Latency:
  - N steps with no hold: start accepted at edge 0; busy high for N cycles; done high in cycle N+1 after acceptance.
  - Each hold cycle adds one cycle.
- Step carry uses the inc_cout present in the cycle the step is taken. q feeds the incrementer combinationally, so inc_sum and inc_cout correspond to the current q.
- ovf stays high through DONE and IDLE until the next accepted load, accepted start, or reset.
- sat_mode changes during RUN have no effect.

Test Plan:
- Reset: assert rst_n=0 mid-run with q=7 -> q=0, busy=0, done=0, ovf=0 asynchronously. After release, state is IDLE.
- Load then run: load_val=3, then start with step_count=4, sat_mode=0 -> q steps 4,5,6,7 on consecutive cycles. busy is high for 4 cycles, then done pulses for 1 cycle, ovf=0.
- Wrap: load 14, start step_count=3, sat_mode=0 -> q goes 15, 0, 1. ovf set on the 15->0 step and remains 1 after done.
- Saturate: load 13, start step_count=5, sat_mode=1 -> q goes 14, 15, 15, 15, 15. ovf=1 and done pulses after the 5th step.
- Hold and zero count: a run of 2 with hold=1 for 2 cycles between steps -> busy is high for 4 cycles and q advances only on non-hold cycles. Separately, start with step_count=0 -> done pulses on the next cycle, busy never rises, q unchanged.
- Priority and ignore: load=1 and start=1 together in IDLE -> q=load_val and no run starts. load=1 during RUN -> ignored, and q continues incrementing.

Source files
------------

// File: rtl/incr_step_reg.sv
// Operand register around an external ripple incrementer: loads a value, then
// runs a programmed number of increment steps with wrap/saturate and sticky overflow.
module incr_step_reg #(
    parameter int unsigned       WIDTH     = 4,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic [WIDTH-1:0] step_count,
    input  logic             hold,
    input  logic             sat_mode,
    input  logic [WIDTH-1:0] inc_sum,
    input  logic             inc_cout,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] remaining, remaining_next;
    logic [WIDTH-1:0] q_next;
    logic             ovf_next;
    logic             sat_r, sat_next;

    // State and datapath registers; busy/done are registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            q         <= RESET_VAL;
            remaining <= '0;
            ovf       <= 1'b0;
            sat_r     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            q         <= q_next;
            remaining <= remaining_next;
            ovf       <= ovf_next;
            sat_r     <= sat_next;
            busy      <= (state_next == RUN);
            done      <= (state_next == DONE);
        end
    end

    always_comb begin
        state_next     = state;
        q_next         = q;
        remaining_next = remaining;
        ovf_next       = ovf;
        sat_next       = sat_r;
        case (state)
            IDLE: begin
                if (load) begin
                    q_next   = load_val;
                    ovf_next = 1'b0;
                end else if (start) begin
                    ovf_next       = 1'b0;
                    sat_next       = sat_mode;
                    remaining_next = step_count;
                    state_next     = (step_count != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (!hold) begin
                    // A carry out means q was all-ones: saturate holds it, wrap takes the sum
                    if (inc_cout) begin
                        ovf_next = 1'b1;
                        if (!sat_r) begin
                            q_next = inc_sum;
                        end
                    end else begin
                        q_next = inc_sum;
                    end
                    remaining_next = remaining - WIDTH'(1);
                    if (remaining == WIDTH'(1)) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
